uart_tx_fifo: RTL

Parametrised, buffered UART transmitter that serialises queued command bytes onto a single TX line. It generalises the fixed 8N1, 57600-baud, 10-bit-frame link used between host and FPGA, adding configurable data width, parity, stop bits, inter-frame gap and a write FIFO. The block sits in the FPGA top level, driving the host-facing UART pin, and can also serve as a synthesizable stimulus source for the AD9910 command path.

---
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write FIFO feeding a serialiser with configurable
// data width, parity, stop bits and inter-frame idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1736,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          CLK100MHZ,
    input  logic                          RESET_N,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_en,
    input  logic                          clear_overflow,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          frame_done,
    output logic                          Uart_TXD
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int BAW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int MAXB  = (DATA_BITS > STOP_BITS)
                         ? ((DATA_BITS > GAP_BITS) ? DATA_BITS : GAP_BITS)
                         : ((STOP_BITS > GAP_BITS) ? STOP_BITS : GAP_BITS);
    localparam int BW    = $clog2(MAXB + 1);
    localparam int GAP_N = (GAP_BITS > 0) ? GAP_BITS : 1;

    localparam logic [BAW-1:0] BAUD_LAST = BAW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0]  GAP_LAST  = BW'(GAP_N - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;

    state_t                 state, state_nxt;
    logic [BAW-1:0]         baud_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   bit_end, end_frame, txd_nxt;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   push, pop;
    logic [CW-1:0]          count_nxt;

    // full is the registered flag, so a write while full is dropped even if a pop lands that cycle
    assign push      = wr_en & ~full;
    // the head is popped in the first cycle of START, when the baud counter has just cleared
    assign pop       = (state == S_START) && (baud_cnt == '0);
    assign count_nxt = fifo_count + CW'(push) - CW'(pop);
    assign bit_end   = (baud_cnt == BAUD_LAST);

    always_ff @(posedge CLK100MHZ) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= count_nxt;
            full       <= (count_nxt == CW'(FIFO_DEPTH));
            empty      <= (count_nxt == '0);
            if (wr_en && full)       overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        end_frame = 1'b0;
        case (state)
            S_IDLE:   if (!empty) state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = S_DATA;
            S_DATA:   if (bit_end && bit_cnt == DATA_LAST)
                          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP:   if (bit_end && bit_cnt == STOP_LAST) begin
                          if (GAP_BITS != 0) state_nxt = S_GAP;
                          else               end_frame = 1'b1;
                      end
            S_GAP:    if (bit_end && bit_cnt == GAP_LAST) end_frame = 1'b1;
            default:  state_nxt = S_IDLE;
        endcase
        // chain straight into the next frame when more data is queued
        if (end_frame) state_nxt = empty ? S_IDLE : S_START;
    end

    always_comb begin
        txd_nxt = 1'b1;
        case (state)
            S_START:  txd_nxt = 1'b0;
            S_DATA:   txd_nxt = shreg[0];
            S_PARITY: txd_nxt = par_bit;
            default:  txd_nxt = 1'b1;
        endcase
    end

    // line, busy and frame_done all lag the state by one cycle, so they stay mutually aligned
    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            Uart_TXD   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == S_IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (bit_end) begin
                baud_cnt <= '0;
                bit_cnt  <= bit_cnt + BW'(1);
            end else begin
                baud_cnt <= baud_cnt + BAW'(1);
            end
            if (pop) begin
                shreg   <= mem[rd_ptr];
                par_bit <= (^mem[rd_ptr]) ^ (PARITY == 1);
            end else if (state == S_DATA && bit_end) begin
                shreg   <= shreg >> 1;
            end
            Uart_TXD   <= txd_nxt;
            busy       <= (state != S_IDLE);
            frame_done <= end_frame;
        end
    end
endmodule
